// File: rtl/word_sel_pkg.sv
// Shared types and constants for the word selector and its history buffer.
package word_sel_pkg;

  localparam int RAND_W   = 7;
  localparam int RAND_MAX = 100;

  typedef enum logic [2:0] {
    IDLE,
    GRAB,
    SETTLE,
    REDUCE,
    CHECK
  } state_t;

endpackage

// File: rtl/word_selector_if.sv
// Request/result bundle between game control, the random generator and the word ROM.
interface word_selector_if;
  import word_sel_pkg::*;

  logic              req;
  logic [RAND_W-1:0] random_num;
  logic              grab_word;
  logic [RAND_W-1:0] word_idx;
  logic              word_valid;
  logic              busy;
  logic              repeat_flag;

  modport master (
    output req, random_num,
    input  grab_word, word_idx, word_valid, busy, repeat_flag
  );

  modport slave (
    input  req, random_num,
    output grab_word, word_idx, word_valid, busy, repeat_flag
  );
endinterface

// File: rtl/word_selector_history.sv
// Shift-register memory of recently issued word indexes (used with WORD_SEL_NOREPEAT_EN).
module word_history
  import word_sel_pkg::*;
#(
  parameter int HIST_DEPTH = 4,
  parameter int W          = RAND_W
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         clear,
  input  logic [W-1:0] cmp,
  output logic         hit
);

  logic [W-1:0]          entry [HIST_DEPTH];
  logic [HIST_DEPTH-1:0] valid;

  // Newest index enters slot 0; the oldest drops off the far end.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid <= '0;
      for (int i = 0; i < HIST_DEPTH; i++) entry[i] <= '0;
    end else if (clear) begin
      valid <= '0;
    end else if (push) begin
      entry[0] <= din;
      valid[0] <= 1'b1;
      for (int i = 1; i < HIST_DEPTH; i++) begin
        entry[i] <= entry[i-1];
        valid[i] <= valid[i-1];
      end
    end
  end

  always_comb begin
    hit = 1'b0;
    for (int i = 0; i < HIST_DEPTH; i++)
      if (valid[i] && (entry[i] == cmp)) hit = 1'b1;
  end

endmodule

// File: rtl/word_selector.sv
// Turns generator values into word-list indexes; repeat rejection is built only
// when WORD_SEL_NOREPEAT_EN is defined.
module word_selector
  import word_sel_pkg::*;
#(
  parameter int NUM_WORDS  = 20,
  parameter int HIST_DEPTH = 4,
  parameter int MAX_RETRY  = 3
) (
  input logic            clk,
  input logic            reset,
  word_selector_if.slave bus
);

  localparam logic [RAND_W-1:0] NUM_V = RAND_W'(NUM_WORDS);

  state_t            state, next_state;
  logic              settle_done;
  logic [RAND_W-1:0] acc;
  logic [RAND_W-1:0] idx_q;
  logic              grab_q, valid_q, flag_q;
  logic              grab_d, valid_d, flag_d;
  logic              hit, retry_ok, accept, acc_ge;

  assign acc_ge = (acc >= NUM_V);
  assign accept = !(hit && retry_ok);

`ifdef WORD_SEL_NOREPEAT_EN
  localparam int RETRY_W = $clog2(MAX_RETRY + 2);
  localparam logic [RETRY_W-1:0] MAX_RETRY_V = RETRY_W'(MAX_RETRY);

  logic [RETRY_W-1:0] retry_cnt;

  assign retry_ok = (retry_cnt < MAX_RETRY_V);

  word_history #(
    .HIST_DEPTH (HIST_DEPTH),
    .W          (RAND_W)
  ) u_history (
    .clk   (clk),
    .reset (reset),
    .push  (valid_d),
    .din   (acc),
    .clear (1'b0),
    .cmp   (acc),
    .hit   (hit)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset)               retry_cnt <= '0;
    else if (state == CHECK) retry_cnt <= accept ? '0 : retry_cnt + 1'b1;
  end
`else
  localparam int unused_cfg = HIST_DEPTH + MAX_RETRY;

  assign hit      = 1'b0;
  assign retry_ok = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  // SETTLE spans the grab pulse plus one more cycle before random_num is trusted.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (bus.req) next_state = GRAB;
      GRAB:    next_state = SETTLE;
      SETTLE:  if (settle_done) next_state = REDUCE;
      REDUCE:  if (!acc_ge) next_state = CHECK;
      CHECK:   next_state = accept ? IDLE : GRAB;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    grab_d  = (state == GRAB);
    valid_d = (state == CHECK) && accept;
    flag_d  = valid_d && hit;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      settle_done <= 1'b0;
      acc         <= '0;
      idx_q       <= '0;
      grab_q      <= 1'b0;
      valid_q     <= 1'b0;
      flag_q      <= 1'b0;
    end else begin
      settle_done <= (state == SETTLE) && !settle_done;
      grab_q      <= grab_d;
      valid_q     <= valid_d;
      flag_q      <= flag_d;
      if (state == SETTLE && settle_done)
        acc <= (bus.random_num == '0) ? '0 : bus.random_num - RAND_W'(1);
      else if (state == REDUCE && acc_ge)
        acc <= acc - NUM_V;
      if (valid_d) idx_q <= acc;
    end
  end

  assign bus.grab_word   = grab_q;
  assign bus.word_valid  = valid_q;
  assign bus.repeat_flag = flag_q;
  assign bus.word_idx    = idx_q;
  assign bus.busy        = (state != IDLE);

endmodule
